// File: rtl/nn_pkg.sv
// Shared sizes, frame word indices and FSM state codes
// for the 2-2-1 network parameter loader.
package nn_pkg;

    localparam int DATA_W    = 16;
    localparam int N_IN      = 2;
    localparam int N_HID     = 2;
    localparam int NUM_WORDS = N_IN + N_HID*(N_IN+1) + N_HID + 1;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    localparam int IDX_X0   = 0;
    localparam int IDX_W1_0 = IDX_X0 + N_IN;
    localparam int IDX_W2_0 = IDX_W1_0 + N_IN + 1;
    localparam int IDX_V_0  = IDX_W2_0 + N_IN + 1;

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] COMMIT  = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/nn_param_loader_if.sv
// Valid/ready word stream used for both the parameter
// input and the sampled-result output.
interface nn_param_loader_if #(
    parameter int W = 16
);

    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/nn_shadow_regs.sv
// Indexed write-enable register file holding one frame,
// read out flat with word 0 in the LSBs.
module nn_shadow_regs
    import nn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  word_t                       data_i,
    output logic [NUM_WORDS*DATA_W-1:0] flat_o
);

    word_t mem_q [NUM_WORDS];

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else if (we_i && idx_i == IDX_W'(i)) begin
                mem_q[i] <= data_i;
            end
        end

        assign flat_o[i*DATA_W +: DATA_W] = mem_q[i];
    end

endmodule

// File: rtl/nn_param_loader.sv
// Loads a frame of network parameters, commits it atomically,
// waits for the network to settle and returns the sampled output.
module nn_param_loader
    import nn_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    nn_param_loader_if.slave          s,
    nn_param_loader_if.master         m,
    output logic [N_IN*DATA_W-1:0]    x_o,
    output logic [(N_IN+1)*DATA_W-1:0] w1_o,
    output logic [(N_IN+1)*DATA_W-1:0] w2_o,
    output logic [(N_HID+1)*DATA_W-1:0] v_o,
    input  logic [DATA_W-1:0]         y_i,
    output logic                      frame_err
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_WORDS*DATA_W-1:0] act_q;
    logic [NUM_WORDS*DATA_W-1:0] shadow;
    word_t            mdata_q;
    logic             mvalid_q, mvalid_d;
    logic             ferr_q, ferr_d;
    logic             commit, sample, hs;

    assign s.ready = (state_q == LOAD) && !rst;
    assign hs      = s.valid && s.ready;

    nn_shadow_regs u_shadow (
        .clk    (clk),
        .rst    (rst),
        .we_i   (hs),
        .idx_i  (idx_q),
        .data_i (s.data),
        .flat_o (shadow)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mvalid_d = mvalid_q;
        ferr_d   = 1'b0;
        commit   = 1'b0;
        sample   = 1'b0;
        case (state_q)
            LOAD: begin
                if (hs) begin
                    idx_d = idx_q + 1'b1;
                    // Frame ends on s_last or on the final slot, whichever comes first
                    if (s.last || idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s.last && idx_q == IDX_LAST) begin
                            state_d = COMMIT;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sample   = 1'b1;
                    mvalid_d = 1'b1;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (m.ready) begin
                    mvalid_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            cnt_q    <= '0;
            act_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mvalid_q <= mvalid_d;
            ferr_q   <= ferr_d;
            if (commit) begin
                act_q <= shadow;
            end
            if (sample) begin
                mdata_q <= y_i;
            end
        end
    end

    assign x_o  = act_q[IDX_X0*DATA_W   +: N_IN*DATA_W];
    assign w1_o = act_q[IDX_W1_0*DATA_W +: (N_IN+1)*DATA_W];
    assign w2_o = act_q[IDX_W2_0*DATA_W +: (N_IN+1)*DATA_W];
    assign v_o  = act_q[IDX_V_0*DATA_W  +: (N_HID+1)*DATA_W];

    assign m.data    = mdata_q;
    assign m.valid   = mvalid_q;
    assign m.last    = 1'b0;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_nn_param_loader.sv
// Randomised bench for nn_param_loader with a frame-level
// reference model and a per-cycle compare process.
module tb_nn_param_loader;
    import nn_pkg::*;

    localparam int SC = 2;
    localparam word_t K = 16'h1234 ^ 16'hFEEF ^ 16'h0100;

    typedef word_t frame_t [NUM_WORDS];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_param_loader_if #(.W(DATA_W)) s_if ();
    nn_param_loader_if #(.W(DATA_W)) m_if ();

    logic [31:0] x_o;
    logic [47:0] w1_o, w2_o, v_o;
    word_t       y_q = '0;
    logic        frame_err;

    nn_param_loader #(.SETTLE_CYC(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s_if),
        .m         (m_if),
        .x_o       (x_o),
        .w1_o      (w1_o),
        .w2_o      (w2_o),
        .v_o       (v_o),
        .y_i       (y_q),
        .frame_err (frame_err)
    );

    // Stand-in network: registered, equals 1234 for the reference frame
    always @(posedge clk) y_q <= x_o[15:0] ^ v_o[47:32] ^ K;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: frame assembly queue plus commit/present timestamps
    bit     in_load = 1'b1;
    word_t  q [$];
    frame_t act = '{default: '0};
    frame_t pend = '{default: '0};
    int     cyc = 0;
    int     commit_at = -1;
    int     present_at = -1;
    bit     e_mval = 1'b0;
    bit     e_ferr = 1'b0;
    word_t  e_mdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_load = 1'b1;
            q.delete();
            act = '{default: '0};
            commit_at = -1;
            present_at = -1;
            e_mval = 1'b0;
            e_ferr = 1'b0;
            e_mdata = '0;
        end else begin
            cyc++;
            e_ferr = 1'b0;
            if (e_mval && m_if.ready) begin
                e_mval = 1'b0;
                in_load = 1'b1;
            end else if (in_load && s_if.valid) begin
                q.push_back(s_if.data);
                if (s_if.last || q.size() == NUM_WORDS) begin
                    if (s_if.last && q.size() == NUM_WORDS) begin
                        for (int i = 0; i < NUM_WORDS; i++) pend[i] = q[i];
                        in_load = 1'b0;
                        commit_at = cyc + 1;
                        present_at = cyc + 1 + SC;
                    end else begin
                        e_ferr = 1'b1;
                    end
                    q.delete();
                end
            end
            if (cyc == commit_at) act = pend;
            if (cyc == present_at) begin
                e_mval = 1'b1;
                e_mdata = act[IDX_X0] ^ act[NUM_WORDS-1] ^ K;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            chk("x_o", x_o, {act[1], act[0]});
            chk("w1_o", w1_o, {act[4], act[3], act[2]});
            chk("w2_o", w2_o, {act[7], act[6], act[5]});
            chk("v_o", v_o, {act[10], act[9], act[8]});
            chk("s_ready", s_if.ready, in_load);
            chk("m_valid", m_if.valid, e_mval);
            chk("frame_err", frame_err, e_ferr);
            if (e_mval) chk("m_data", m_if.data, e_mdata);
        end
    end

    task automatic send(input frame_t w, input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_if.valid = 1'b0;
                s_if.data  = word_t'($urandom);
                s_if.last  = 1'($urandom);
                @(negedge clk);
            end
            s_if.valid = 1'b1;
            s_if.data  = w[i];
            s_if.last  = (i == last_at);
            for (int t = 0; t < 100 && !s_if.ready; t++) @(negedge clk);
            chk("ready_wait", s_if.ready, 1'b1);
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic collect(input int hold, output word_t d);
        for (int t = 0; t < 20 && !m_if.valid; t++) @(negedge clk);
        chk("m_valid_wait", m_if.valid, 1'b1);
        d = m_if.data;
        repeat (hold) begin
            @(negedge clk);
            chk("m_data_hold", m_if.data, d);
            chk("s_ready_hold", s_if.ready, 1'b0);
        end
        m_if.ready = 1'b1;
        @(negedge clk);
        m_if.ready = 1'b0;
        chk("s_ready_after", s_if.ready, 1'b1);
    endtask

    task automatic check_e_plus(input word_t y);
        chk("lat_E0", m_if.valid, 1'b0);
        @(negedge clk);
        chk("lat_E1_x", x_o, 32'h0200_FEEF);
        chk("lat_E1_w1", w1_o, 48'h0505_0400_0120);
        chk("lat_E1_w2", w2_o, 48'h0210_FD00_00A7);
        chk("lat_E1_v", v_o, 48'h0100_FF00_0080);
        chk("lat_E1_mv", m_if.valid, 1'b0);
        @(negedge clk);
        chk("lat_E2_mv", m_if.valid, 1'b0);
        @(negedge clk);
        chk("lat_E3_mv", m_if.valid, 1'b1);
        chk("lat_E3_md", m_if.data, y);
    endtask

    frame_t f1 = '{16'hFEEF, 16'h0200, 16'h0120, 16'h0400, 16'h0505, 16'h00A7,
                   16'hFD00, 16'h0210, 16'h0080, 16'hFF00, 16'h0100};
    frame_t fr;
    word_t  d;
    int     fc;

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", x_o, 32'h0);
        chk("rst_v", v_o, 48'h0);
        chk("rst_mv", m_if.valid, 1'b0);
        chk("rst_md", m_if.data, 16'h0);
        chk("rst_sr", s_if.ready, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send(f1, NUM_WORDS, NUM_WORDS-1, 1'b0);
        check_e_plus(16'h1234);
        collect(0, d);

        fc = ferr_cnt;
        for (int i = 0; i < NUM_WORDS; i++) fr[i] = word_t'($urandom);
        send(fr, 7, 6, 1'b0);
        repeat (2) @(negedge clk);
        chk("early_last_ferr", ferr_cnt - fc, 1);
        chk("early_last_keep", x_o, 32'h0200_FEEF);
        send(fr, NUM_WORDS, NUM_WORDS-1, 1'b0);
        collect(1, d);

        fc = ferr_cnt;
        send(f1, NUM_WORDS, -1, 1'b0);
        repeat (6) @(negedge clk);
        chk("no_last_ferr", ferr_cnt - fc, 1);
        chk("no_last_mv", m_if.valid, 1'b0);

        send(f1, NUM_WORDS, NUM_WORDS-1, 1'b0);
        collect(5, d);
        chk("hold_data", d, 16'h1234);

        send(f1, NUM_WORDS, NUM_WORDS-1, 1'b1);
        check_e_plus(16'h1234);
        collect(0, d);

        send(fr, 5, -1, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_x", x_o, 32'h0);
        chk("arst_w1", w1_o, 48'h0);
        chk("arst_sr", s_if.ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_sr", s_if.ready, 1'b1);
        send(f1, NUM_WORDS, NUM_WORDS-1, 1'b0);
        collect(0, d);
        chk("arst_reload", d, 16'h1234);

        for (int r = 0; r < 40; r++) begin
            int kind;
            int la;
            for (int i = 0; i < NUM_WORDS; i++) fr[i] = word_t'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                la = $urandom_range(0, NUM_WORDS-2);
                send(fr, la + 1, la, 1'($urandom));
            end else if (kind == 1) begin
                send(fr, NUM_WORDS, -1, 1'($urandom));
            end else begin
                send(fr, NUM_WORDS, NUM_WORDS-1, 1'($urandom));
                collect($urandom_range(0, 3), d);
            end
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
